serial_demux_8_deserializer: RTL and testbench

- Receive end of the 8-to-1 mux serializer path: takes one serial bit per valid cycle and steers it through a 1-to-8 demux into an 8-bit assembly register.
- Select index counts 0..7, mirroring the mux select sequence on the transmit side.
- Completed words go out through a single-entry valid/ready holding register.
- Sits between the serial link and the pipeline's parallel consumers.

---
 rtl/serial_demux_8_deserializer_pkg.sv | 13 +
 rtl/serial_demux_8_deserializer_if.sv | 25 ++
 rtl/serial_demux_8_deserializer_demux_1_to_8.sv | 17 +
 rtl/serial_demux_8_deserializer.sv | 84 ++++++++
 tb/tb_serial_demux_8_deserializer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/serial_demux_8_deserializer_pkg.sv
// Shared constants and state encoding for the serial-to-parallel receive path.
// Imported by the deserializer top and its demux.
package serial_demux_8_deserializer_pkg;

   localparam int N     = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

endpackage

// File: rtl/serial_demux_8_deserializer_if.sv
// Serial input link plus parallel valid/ready output of the deserializer.
// The slave modport is the deserializer; master is the link driver/consumer.
interface serial_demux_8_deserializer_if;
   import serial_demux_8_deserializer_pkg::*;

   logic             serial_in;
   logic             in_valid;
   logic             frame_start;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic [N-1:0]     out_data;
   logic             out_valid;
   logic             out_ready;
   logic             overrun;

   modport slave (
      input  serial_in, in_valid, frame_start, out_ready,
      output sel, busy, out_data, out_valid, overrun
   );

   modport master (
      output serial_in, in_valid, frame_start, out_ready,
      input  sel, busy, out_data, out_valid, overrun
   );
endinterface

// File: rtl/serial_demux_8_deserializer_demux_1_to_8.sv
// 1-to-8 demux: routes d onto output y[s] when en is high, all other outputs 0.
// Inverse of the transmit-side 8-to-1 mux; used as assembly write enables.
module demux_1_to_8
   import serial_demux_8_deserializer_pkg::*;
(
   input  logic             d,
   input  logic             en,
   input  logic [SEL_W-1:0] s,
   output logic [N-1:0]     y
);

   always_comb begin
      y    = '0;
      y[s] = d & en;
   end

endmodule

// File: rtl/serial_demux_8_deserializer.sv
// Receive-side deserializer: assembles 8 serial bits into a word and offers it
// through a single-entry valid/ready holding register.
module serial_demux_8_deserializer
   import serial_demux_8_deserializer_pkg::*;
#(
   parameter int LSB_FIRST = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   serial_demux_8_deserializer_if.slave  bus
);

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);

   state_t           r_state;
   logic [SEL_W-1:0] r_sel;
   logic [N-1:0]     r_asm;
   logic [N-1:0]     r_outData;
   logic             r_outValid;
   logic             r_overrun;

   logic [SEL_W-1:0] w_curSel;
   logic [SEL_W-1:0] w_bitIdx;
   logic [N-1:0]     w_base;
   logic [N-1:0]     w_we;
   logic [N-1:0]     w_asmNext;
   logic             w_complete;
   logic             w_accept;

   // frame_start restarts the word: current bit goes to index 0 over a cleared register
   assign w_curSel   = bus.frame_start ? '0 : r_sel;
   assign w_bitIdx   = (LSB_FIRST != 0) ? w_curSel : (LAST_SEL - w_curSel);
   assign w_base     = bus.frame_start ? '0 : r_asm;
   assign w_asmNext  = (w_base & ~w_we) | (w_we & {N{bus.serial_in}});
   assign w_complete = bus.in_valid && !bus.frame_start && (r_sel == LAST_SEL);
   assign w_accept   = r_outValid && bus.out_ready;

   demux_1_to_8 u_demux (
      .d  (1'b1),
      .en (bus.in_valid),
      .s  (w_bitIdx),
      .y  (w_we)
   );

   // A completed word is dropped (with an overrun pulse) only when the holding
   // register is full and not being drained in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_sel      <= '0;
         r_asm      <= '0;
         r_outData  <= '0;
         r_outValid <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_accept) begin
            r_outValid <= 1'b0;
         end
         if (w_complete) begin
            r_asm   <= '0;
            r_sel   <= '0;
            r_state <= IDLE;
            if (!r_outValid || bus.out_ready) begin
               r_outData  <= w_asmNext;
               r_outValid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (bus.frame_start || bus.in_valid) begin
            r_asm   <= w_asmNext;
            r_sel   <= bus.in_valid ? (w_curSel + SEL_W'(1)) : '0;
            r_state <= bus.in_valid ? COLLECT : IDLE;
         end
      end
   end

   assign bus.sel       = r_sel;
   assign bus.busy      = (r_state == COLLECT);
   assign bus.out_data  = r_outData;
   assign bus.out_valid = r_outValid;
   assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_serial_demux_8_deserializer.sv
// Directed bench for the deserializer: expected words go into a scoreboard queue
// and a monitor pops them whenever the DUT hands over a word.
module tb_serial_demux_8_deserializer;

   logic clk;
   logic reset;
   int   checks;
   int   fails;
   logic [7:0] expQ[$];

   serial_demux_8_deserializer_if bus ();

   serial_demux_8_deserializer #(.LSB_FIRST(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus; inputs change 1 time unit after the edge.
   task automatic applyStimulus(input logic b, input logic v, input logic fs);
      bus.serial_in   = b;
      bus.in_valid    = v;
      bus.frame_start = fs;
      @(posedge clk);
      #1;
      bus.in_valid    = 1'b0;
      bus.frame_start = 1'b0;
      bus.serial_in   = 1'b0;
   endtask

   task automatic sendWord(input logic [7:0] w, input bit gapped);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(w[i], 1'b1, 1'b0);
         if (gapped) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("gap_sel_hold", 32'(bus.sel), 32'((i + 1) % 8));
         end
      end
   endtask

   // Scoreboard monitor: compares every handed-over word against the queue head
   initial begin
      logic [7:0] expWord;
      forever begin
         @(negedge clk);
         if (!reset && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected_word: got %0h expected none", bus.out_data);
            end else begin
               expWord = expQ.pop_front();
               checkOutput("scoreboard_word", 32'(bus.out_data), 32'(expWord));
            end
         end
      end
   end

   initial begin
      int waitCycles;
      checks          = 0;
      fails           = 0;
      reset           = 1'b1;
      bus.serial_in   = 1'b0;
      bus.in_valid    = 1'b0;
      bus.frame_start = 1'b0;
      bus.out_ready   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset_sel", 32'(bus.sel), 32'd0);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_data", 32'(bus.out_data), 32'd0);
      checkOutput("reset_overrun", 32'(bus.overrun), 32'd0);

      // reset in the middle of a word
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("midword_sel", 32'(bus.sel), 32'd3);
      checkOutput("midword_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("midreset_sel", 32'(bus.sel), 32'd0);
      checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
      checkOutput("midreset_valid", 32'(bus.out_valid), 32'd0);
      expQ.push_back(8'h96);
      sendWord(8'h96, 1'b0);
      checkOutput("after_reset_data", 32'(bus.out_data), 32'h96);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // back-to-back bits 1,0,1,1,0,0,1,0
      expQ.push_back(8'h4D);
      sendWord(8'h4D, 1'b0);
      checkOutput("lsb_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("lsb_data", 32'(bus.out_data), 32'h4D);
      checkOutput("lsb_busy_idle", 32'(bus.busy), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("lsb_valid_one_cycle", 32'(bus.out_valid), 32'd0);

      // same word with idle cycles between bits
      expQ.push_back(8'h4D);
      sendWord(8'h4D, 1'b1);
      checkOutput("gapped_data", 32'(bus.out_data), 32'h4D);

      // backpressure: second word is dropped
      bus.out_ready = 1'b0;
      expQ.push_back(8'hA5);
      sendWord(8'hA5, 1'b0);
      checkOutput("bp_first_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_no_overrun_yet", 32'(bus.overrun), 32'd0);
      sendWord(8'h3C, 1'b0);
      checkOutput("bp_overrun_pulse", 32'(bus.overrun), 32'd1);
      checkOutput("bp_data_held", 32'(bus.out_data), 32'hA5);
      checkOutput("bp_valid_held", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_sel_wrapped", 32'(bus.sel), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("bp_overrun_single", 32'(bus.overrun), 32'd0);
      bus.out_ready = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);

      // accept and complete in the same cycle
      bus.out_ready = 1'b0;
      expQ.push_back(8'h11);
      sendWord(8'h11, 1'b0);
      expQ.push_back(8'h22);
      begin
         logic [7:0] w;
         w = 8'h22;
         for (int i = 0; i < 7; i++) applyStimulus(w[i], 1'b1, 1'b0);
         bus.out_ready = 1'b1;
         applyStimulus(w[7], 1'b1, 1'b0);
      end
      checkOutput("simul_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("simul_data", 32'(bus.out_data), 32'h22);
      checkOutput("simul_overrun", 32'(bus.overrun), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("simul_drained", 32'(bus.out_valid), 32'd0);

      // frame_start with in_valid realigns onto the current bit
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("fs_sel", 32'(bus.sel), 32'd1);
      checkOutput("fs_busy", 32'(bus.busy), 32'd1);
      expQ.push_back(8'h01);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("fs_data", 32'(bus.out_data), 32'h01);

      // frame_start without in_valid clears the partial word
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("fs_idle_sel", 32'(bus.sel), 32'd0);
      checkOutput("fs_idle_busy", 32'(bus.busy), 32'd0);
      expQ.push_back(8'h5A);
      sendWord(8'h5A, 1'b0);
      checkOutput("fs_idle_data", 32'(bus.out_data), 32'h5A);

      waitCycles = 0;
      while (expQ.size() != 0 && waitCycles < 20) begin
         @(posedge clk);
         waitCycles++;
      end
      #1;
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
